// File: rtl/bdc_pkg.sv
// Shared definitions for the brushed-DC channel sequencer: host register map,
// CTRL bit positions, tach-read FSM states and the read-response record.
package bdc_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_TARGET = 3'd1;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_TACHL  = 3'd3;
  localparam logic [2:0] ADDR_TACHH  = 3'd4;
  localparam logic [2:0] ADDR_DUTY   = 3'd5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_RUN    = 1;
  localparam int CTRL_INVPWM = 2;
  localparam int CTRL_INVPH  = 3;
  localparam int CTRL_RAMP   = 4;
  localparam int CTRL_FCLR   = 7;

  typedef enum logic [1:0] {
    TS_IDLE = 2'd0,
    TS_FRZ  = 2'd1,
    TS_HOLD = 2'd2
  } tach_state_e;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } rd_rsp_t;

endpackage

// File: rtl/bdc_channel_sequencer_if.sv
// Host register bus for one motor channel.
//   addr/wr/rd/wrtdata : host -> sequencer, one-cycle strobes
//   rddata/rdvalid     : sequencer -> host, one response pulse per read
interface bdc_channel_sequencer_if;
  logic [2:0] addr;
  logic       wr;
  logic       rd;
  logic [7:0] wrtdata;
  logic [7:0] rddata;
  logic       rdvalid;

  modport master (output addr, wr, rd, wrtdata, input rddata, rdvalid);
  modport slave  (input addr, wr, rd, wrtdata, output rddata, rdvalid);
endinterface

// File: rtl/bdc_ce_divider.sv
// Free-running clock-enable generator.
//   clk, reset : clock, synchronous active-high reset
//   ce         : one-cycle pulse every DIV cycles, first at cycle DIV-1
//                after reset release (DIV=1 gives a constant-high enable)
module bdc_ce_divider #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic reset,
  output logic ce
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign ce = (cnt_q == LAST);

  always_comb cnt_d = ce ? '0 : cnt_q + W'(1);

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/bdc_channel_sequencer.sv
// Control/sequencing front end for one brushed DC motor channel.
//   clk, reset     : clock, synchronous active-high reset
//   host           : register bus (CTRL, TARGET, STATUS, TACHL, TACHH, DUTY)
//   countl/counth  : tach count bytes from the channel counter
//   currentlimit   : overcurrent indication from the power stage
//   filterce/pwmcntce : divided clock enables for tach filter / PWM counter
//   pwmldce/pwmdata   : PWM duty load strobe and duty value
//   freeze         : holds the tach counter during a two-byte read
//   invphase/invertpwm/enablepwm/run : channel control bits
module bdc_channel_sequencer
  import bdc_pkg::*;
#(
  parameter int FILTER_DIV     = 16,
  parameter int PWM_DIV        = 4,
  parameter int RAMP_DIV       = 256,
  parameter int ILIMIT_MAX     = 8,
  parameter int FREEZE_TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  bdc_channel_sequencer_if.slave   host,
  input  logic [7:0]               countl,
  input  logic [7:0]               counth,
  input  logic                     currentlimit,
  output logic                     filterce,
  output logic                     pwmcntce,
  output logic                     pwmldce,
  output logic [7:0]               pwmdata,
  output logic                     freeze,
  output logic                     invphase,
  output logic                     invertpwm,
  output logic                     enablepwm,
  output logic                     run
);
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int TW = $clog2(FREEZE_TIMEOUT + 1);

  logic [4:0]    ctrl_q, ctrl_d;
  logic [7:0]    target_q, target_d, duty_q, duty_d;
  logic          fault_q, fault_d, ld_q, ld_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [7:0]    pcnt_q, pcnt_d, consec_q, consec_d;
  logic          lim_q, lim_d;
  tach_state_e   st_q, st_d;
  logic          freeze_q, freeze_d;
  logic [TW-1:0] tmo_q, tmo_d;
  rd_rsp_t       rsp_q, rsp_d;
  logic          pend_q, pend_d;
  logic [2:0]    pend_addr_q, pend_addr_d;

  logic       wr_ctrl, wr_tgt, fclr, rtick, pbnd, lim_now, fset, ramp_busy, svc;
  logic [2:0] saddr;
  logic [7:0] reg_rdata;
  logic       unused;

  bdc_ce_divider #(.DIV(FILTER_DIV)) u_filt_ce (.clk(clk), .reset(reset), .ce(filterce));
  bdc_ce_divider #(.DIV(PWM_DIV))    u_pwm_ce  (.clk(clk), .reset(reset), .ce(pwmcntce));

  assign wr_ctrl   = host.wr && (host.addr == ADDR_CTRL);
  assign wr_tgt    = host.wr && (host.addr == ADDR_TARGET);
  assign fclr      = wr_ctrl && host.wrtdata[CTRL_FCLR] && !currentlimit;
  assign rtick     = (rcnt_q == RW'(RAMP_DIV - 1));
  // Last pwmcntce of a 256-pulse PWM period closes the period.
  assign pbnd      = pwmcntce && (pcnt_q == 8'hFF);
  assign lim_now   = lim_q | currentlimit;
  assign fset      = pbnd && lim_now && (consec_q == 8'(ILIMIT_MAX - 1));
  assign ramp_busy = ctrl_q[CTRL_RAMP] && (duty_q != target_q);
  assign unused    = ^host.wrtdata[6:5];

  // Duty ramp, register writes and overcurrent fault.
  always_comb begin
    rcnt_d   = rtick ? '0 : rcnt_q + RW'(1);
    pcnt_d   = pwmcntce ? pcnt_q + 8'd1 : pcnt_q;
    lim_d    = pbnd ? 1'b0 : lim_now;
    consec_d = consec_q;
    if (pbnd) consec_d = (lim_now && !fset) ? consec_q + 8'd1 : 8'd0;
    ctrl_d   = wr_ctrl ? host.wrtdata[4:0] : ctrl_q;
    target_d = wr_tgt ? host.wrtdata : target_q;
    duty_d   = duty_q;
    ld_d     = 1'b0;
    if (wr_tgt && !ctrl_q[CTRL_RAMP]) begin
      duty_d = host.wrtdata;
      ld_d   = 1'b1;
    end else if (ctrl_q[CTRL_RAMP] && rtick && (duty_q != target_d)) begin
      // Step toward the incoming target so a mid-ramp retarget never
      // takes a step the wrong way.
      duty_d = (target_d > duty_q) ? duty_q + 8'd1 : duty_q - 8'd1;
      ld_d   = 1'b1;
    end
    if (fset) begin
      target_d = 8'd0;
      duty_d   = 8'd0;
      ld_d     = 1'b1;
    end
    fault_d = fset ? 1'b1 : (fclr ? 1'b0 : fault_q);
  end

  always_comb begin
    reg_rdata = 8'd0;
    case (saddr)
      ADDR_CTRL:   reg_rdata = {3'd0, ctrl_q};
      ADDR_TARGET: reg_rdata = target_q;
      ADDR_STATUS: reg_rdata = {5'd0, freeze_q, ramp_busy, fault_q};
      ADDR_TACHL:  reg_rdata = countl;
      ADDR_TACHH:  reg_rdata = counth;
      ADDR_DUTY:   reg_rdata = duty_q;
      default:     reg_rdata = 8'd0;
    endcase
  end

  // Read servicing and tach-freeze FSM. The FRZ cycle owns the response
  // slot for the low byte; a host read landing there is parked one cycle.
  always_comb begin
    st_d        = st_q;
    freeze_d    = freeze_q;
    tmo_d       = tmo_q;
    rsp_d       = '0;
    svc         = 1'b0;
    saddr       = pend_q ? pend_addr_q : host.addr;
    pend_d      = pend_q & host.rd;
    pend_addr_d = host.addr;
    if (st_q == TS_FRZ) begin
      rsp_d.vld   = 1'b1;
      rsp_d.data  = countl;
      st_d        = TS_HOLD;
      tmo_d       = '0;
      pend_d      = pend_q | host.rd;
      pend_addr_d = host.rd ? host.addr : pend_addr_q;
    end else begin
      svc        = pend_q | host.rd;
      rsp_d.vld  = svc;
      rsp_d.data = reg_rdata;
    end
    case (st_q)
      TS_IDLE: begin
        freeze_d = 1'b0;
        if (svc && (saddr == ADDR_TACHL)) begin
          st_d      = TS_FRZ;
          freeze_d  = 1'b1;
          rsp_d.vld = 1'b0;
        end
      end
      TS_HOLD: begin
        tmo_d = tmo_q + TW'(1);
        // High-byte read: freeze stays up through rdvalid, IDLE drops it.
        if (svc && (saddr == ADDR_TACHH)) st_d = TS_IDLE;
        else if (svc && (saddr == ADDR_TACHL)) tmo_d = '0;
        else if (tmo_q == TW'(FREEZE_TIMEOUT - 1)) begin
          st_d     = TS_IDLE;
          freeze_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0; target_q <= '0; duty_q <= '0; fault_q <= 1'b0; ld_q <= 1'b0;
      rcnt_q <= '0; pcnt_q <= '0; consec_q <= '0; lim_q <= 1'b0;
      st_q <= TS_IDLE; freeze_q <= 1'b0; tmo_q <= '0; rsp_q <= '0;
      pend_q <= 1'b0; pend_addr_q <= '0;
    end else begin
      ctrl_q <= ctrl_d; target_q <= target_d; duty_q <= duty_d; fault_q <= fault_d; ld_q <= ld_d;
      rcnt_q <= rcnt_d; pcnt_q <= pcnt_d; consec_q <= consec_d; lim_q <= lim_d;
      st_q <= st_d; freeze_q <= freeze_d; tmo_q <= tmo_d; rsp_q <= rsp_d;
      pend_q <= pend_d; pend_addr_q <= pend_addr_d;
    end
  end

  assign host.rddata  = rsp_q.data;
  assign host.rdvalid = rsp_q.vld;
  assign pwmldce      = ld_q;
  assign pwmdata      = duty_q;
  assign freeze       = freeze_q;
  assign invphase     = ctrl_q[CTRL_INVPH];
  assign invertpwm    = ctrl_q[CTRL_INVPWM];
  assign enablepwm    = ctrl_q[CTRL_EN] & ~fault_q;
  assign run          = ctrl_q[CTRL_RUN] & ~fault_q;
endmodule

// File: tb/tb_bdc_channel_sequencer.sv
// Bench for bdc_channel_sequencer: cycle-level reference model updated on
// each rising edge, compared against every output on each falling edge,
// plus directed scenarios with literal expectations.
module tb_bdc_channel_sequencer;
  localparam int FD = 16, PD = 4, RD = 4, IM = 8, FT = 1024;

  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] countl = 8'h34, counth = 8'h56;
  logic currentlimit = 1'b0;
  logic filterce, pwmcntce, pwmldce, freeze, invphase, invertpwm, enablepwm, run;
  logic [7:0] pwmdata;

  bdc_channel_sequencer_if host ();

  bdc_channel_sequencer #(
    .FILTER_DIV(FD), .PWM_DIV(PD), .RAMP_DIV(RD), .ILIMIT_MAX(IM), .FREEZE_TIMEOUT(FT)
  ) dut (
    .clk(clk), .reset(reset), .host(host), .countl(countl), .counth(counth),
    .currentlimit(currentlimit), .filterce(filterce), .pwmcntce(pwmcntce),
    .pwmldce(pwmldce), .pwmdata(pwmdata), .freeze(freeze), .invphase(invphase),
    .invertpwm(invertpwm), .enablepwm(enablepwm), .run(run)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit       m_started = 0;
  int       cyc = 0, m_consec = 0, tph = 0, age = 0;
  bit [7:0] m_ctrl = 0, m_target = 0, m_duty = 0, m_rdat = 0;
  bit       m_fault = 0, m_ld = 0, m_lim = 0, m_freeze = 0, m_rv = 0;

  function automatic bit [7:0] regval(input bit [2:0] a);
    case (a)
      3'd0: return m_ctrl;
      3'd1: return m_target;
      3'd2: return {5'd0, m_freeze, m_ctrl[4] && (m_duty != m_target), m_fault};
      3'd3: return countl;
      3'd4: return counth;
      3'd5: return m_duty;
      default: return 8'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit tick, bnd, fset, clr, oldramp, rv;
    bit [7:0] rdat;
    if (reset) begin
      cyc = 0; m_ctrl = 0; m_target = 0; m_duty = 0; m_fault = 0; m_ld = 0;
      m_lim = 0; m_consec = 0; tph = 0; age = 0; m_freeze = 0; m_rv = 0; m_rdat = 0;
      m_started = 1;
    end else begin
      tick = (cyc % RD) == RD - 1;
      bnd  = ((cyc % PD) == PD - 1) && (((cyc + 1) / PD) % 256 == 0);
      rv = 0; rdat = 0;
      if (tph == 1) begin
        rv = 1; rdat = countl; tph = 2; age = 0;
      end else if (tph == 2) begin
        if (host.rd) begin rv = 1; rdat = regval(host.addr); end
        if (host.rd && host.addr == 3'd4) tph = 0;
        else if (host.rd && host.addr == 3'd3) age = 0;
        else begin
          age++;
          if (age == FT) begin tph = 0; m_freeze = 0; end
        end
      end else begin
        m_freeze = 0;
        if (host.rd && host.addr == 3'd3) begin tph = 1; m_freeze = 1; end
        else if (host.rd) begin rv = 1; rdat = regval(host.addr); end
      end
      fset = 0;
      if (bnd) begin
        if (m_lim || currentlimit) m_consec++; else m_consec = 0;
        if (m_consec == IM) begin fset = 1; m_consec = 0; end
        m_lim = 0;
      end else if (currentlimit) m_lim = 1;
      clr = host.wr && host.addr == 3'd0 && host.wrtdata[7] && !currentlimit;
      oldramp = m_ctrl[4];
      m_ld = 0;
      if (host.wr && host.addr == 3'd0) m_ctrl = host.wrtdata & 8'h1f;
      if (host.wr && host.addr == 3'd1) begin
        m_target = host.wrtdata;
        if (!oldramp) begin m_duty = m_target; m_ld = 1; end
      end
      if (oldramp && tick && m_duty != m_target) begin
        m_duty = (m_target > m_duty) ? m_duty + 8'd1 : m_duty - 8'd1;
        m_ld = 1;
      end
      if (fset) begin m_target = 0; m_duty = 0; m_ld = 1; m_fault = 1; end
      else if (clr) m_fault = 0;
      m_rv = rv; m_rdat = rdat;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("filterce", filterce, (cyc % FD) == FD - 1);
      check("pwmcntce", pwmcntce, (cyc % PD) == PD - 1);
      check("rdvalid", host.rdvalid, m_rv);
      if (m_rv) check("rddata", host.rddata, m_rdat);
      check("pwmldce", pwmldce, m_ld);
      check("pwmdata", pwmdata, m_duty);
      check("freeze", freeze, m_freeze);
      check("invphase", invphase, m_ctrl[3]);
      check("invertpwm", invertpwm, m_ctrl[2]);
      check("enablepwm", enablepwm, m_ctrl[0] && !m_fault);
      check("run", run, m_ctrl[1] && !m_fault);
    end
  end

  // Load-strobe log, sampled clear of both clock edges.
  int tcyc = 0;
  int ldt[$];
  bit [7:0] ldq[$];
  always @(posedge clk) begin
    #2;
    tcyc++;
    if (pwmldce) begin ldq.push_back(pwmdata); ldt.push_back(tcyc); end
  end

  // ---------------- stimulus ----------------
  task automatic do_rd(input logic [2:0] a);
    host.addr = a; host.rd = 1'b1; @(negedge clk); host.rd = 1'b0;
  endtask
  task automatic do_wr(input logic [2:0] a, input logic [7:0] d);
    host.addr = a; host.wrtdata = d; host.wr = 1'b1; @(negedge clk); host.wr = 1'b0;
  endtask
  task automatic do_wrrd(input logic [2:0] a, input logic [7:0] d);
    host.addr = a; host.wrtdata = d; host.wr = 1'b1; host.rd = 1'b1;
    @(negedge clk); host.wr = 1'b0; host.rd = 1'b0;
  endtask

  initial begin
    int nf, np, n;
    host.addr = 3'd0; host.wr = 1'b0; host.rd = 1'b0; host.wrtdata = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Dividers and reset state over the first 64 cycles.
    check("reset pwmdata", pwmdata, 8'h00);
    check("reset enablepwm", enablepwm, 1'b0);
    check("reset rdvalid", host.rdvalid, 1'b0);
    nf = 0; np = 0;
    for (int i = 0; i < 64; i++) begin
      if (filterce) nf++;
      if (pwmcntce) np++;
      if (i == 14) check("filterce c14", filterce, 1'b0);
      if (i == 15) check("filterce c15", filterce, 1'b1);
      if (i == 3)  check("pwmcntce c3", pwmcntce, 1'b1);
      @(negedge clk);
    end
    check("filterce count", nf, 4);
    check("pwmcntce count", np, 16);

    // Atomic two-byte tach read.
    do_rd(3'd3);
    check("tachl freeze +1", freeze, 1'b1);
    check("tachl rdvalid +1", host.rdvalid, 1'b0);
    @(negedge clk);
    check("tachl rdvalid +2", host.rdvalid, 1'b1);
    check("tachl data", host.rddata, 8'h34);
    countl = 8'h77; counth = 8'h12;
    repeat (3) @(negedge clk);
    do_rd(3'd4);
    check("tachh rdvalid", host.rdvalid, 1'b1);
    check("tachh data", host.rddata, 8'h12);
    check("freeze at tachh rdvalid", freeze, 1'b1);
    @(negedge clk);
    check("freeze after tachh", freeze, 1'b0);

    // Freeze timeout.
    do_rd(3'd3);
    @(negedge clk);
    n = 0;
    while (freeze && n < 3000) begin n++; @(negedge clk); end
    check("freeze hold cycles", n, FT);
    do_rd(3'd2);
    check("status after timeout", host.rddata, 8'h00);

    // Direct load, simultaneous write+read, then ramp.
    do_wrrd(3'd1, 8'h40);
    check("wr+rd old target", host.rddata, 8'h00);
    check("direct load strobe", pwmldce, 1'b1);
    check("direct load data", pwmdata, 8'h40);
    do_wr(3'd1, 8'h00);
    do_wr(3'd0, 8'h10);
    ldq.delete(); ldt.delete();
    do_wr(3'd1, 8'd3);
    repeat (20) @(negedge clk);
    check("ramp up pulses", ldq.size(), 3);
    if (ldq.size() == 3) begin
      check("ramp up 1", ldq[0], 8'd1);
      check("ramp up 2", ldq[1], 8'd2);
      check("ramp up 3", ldq[2], 8'd3);
      check("ramp spacing a", ldt[1] - ldt[0], 4);
      check("ramp spacing b", ldt[2] - ldt[1], 4);
    end
    do_rd(3'd2);
    check("ramp idle status", host.rddata, 8'h00);
    ldq.delete(); ldt.delete();
    do_wr(3'd1, 8'd1);
    do_rd(3'd2);
    check("ramp busy status", host.rddata, 8'h02);
    repeat (20) @(negedge clk);
    check("ramp down pulses", ldq.size(), 2);
    if (ldq.size() == 2) begin
      check("ramp down 1", ldq[0], 8'd2);
      check("ramp down 2", ldq[1], 8'd1);
    end

    // Overcurrent fault and clear.
    do_wr(3'd0, 8'h13);
    check("enable before fault", enablepwm, 1'b1);
    check("run before fault", run, 1'b1);
    currentlimit = 1'b1;
    n = 0;
    while (enablepwm && n < 12000) begin n++; @(negedge clk); end
    check("fault latency in range", (n > 7 * 1024) && (n <= 8 * 1024), 1'b1);
    check("fault load strobe", pwmldce, 1'b1);
    check("fault load data", pwmdata, 8'h00);
    check("fault run", run, 1'b0);
    do_wr(3'd0, 8'h93);
    do_rd(3'd2);
    check("clear blocked status", host.rddata, 8'h01);
    do_rd(3'd0);
    check("ctrl readback", host.rddata, 8'h13);
    currentlimit = 1'b0;
    repeat (2) @(negedge clk);
    do_wr(3'd0, 8'h93);
    do_rd(3'd2);
    check("cleared status", host.rddata, 8'h00);
    check("enable after clear", enablepwm, 1'b1);
    do_rd(3'd5);
    check("duty not restored", host.rddata, 8'h00);
    do_rd(3'd6);
    check("unmapped read", host.rddata, 8'h00);

    // Reset in the middle of a ramp and a held tach read.
    do_wr(3'd1, 8'd200);
    repeat (10) @(negedge clk);
    do_rd(3'd3);
    repeat (4) @(negedge clk);
    check("freeze mid-hold", freeze, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("reset freeze", freeze, 1'b0);
    check("reset duty", pwmdata, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    check("no load after reset", pwmldce, 1'b0);
    check("duty after reset", pwmdata, 8'h00);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bdc_channel_sequencer.md
Name: bdc_channel_sequencer

Overview:
- Control and sequencing front end for one brushed DC motor channel (tach counter + 8-bit PWM).
- Generates the tach-filter and PWM-count clock enables.
- Provides a small host register file, an atomic two-byte tach read using freeze, a duty-cycle soft ramp that issues PWM load strobes, and a latched overcurrent fault that shuts the channel down.

Parameters:
- FILTER_DIV, 16: clk cycles per filterce pulse (>=2)
- PWM_DIV, 4: clk cycles per pwmcntce pulse (>=1; 1 = constant high)
- RAMP_DIV, 256: clk cycles between duty ramp steps (>=1)
- ILIMIT_MAX, 8: consecutive PWM periods with currentlimit before fault (1..255)
- FREEZE_TIMEOUT, 1024: clk cycles freeze may be held awaiting the high-byte read

Ports:
- clk, input, 1: system clock
- reset, input, 1: synchronous, active-high reset
- addr, input, 3: host register address
- wr, input, 1: host write strobe, one cycle
- rd, input, 1: host read strobe, one cycle
- wrtdata, input, 8: host write data
- rddata, output, 8: host read data
- rdvalid, output, 1: rddata valid, one-cycle pulse
- countl, input, 8: channel tach count low byte
- counth, input, 8: channel tach count high byte
- currentlimit, input, 1: channel overcurrent indication
- filterce, output, 1: tach filter clock enable
- pwmcntce, output, 1: PWM count enable
- pwmldce, output, 1: PWM load strobe
- pwmdata, output, 8: duty value presented with pwmldce
- freeze, output, 1: tach counter freeze
- invphase, output, 1: tach phase invert
- invertpwm, output, 1: PWM polarity invert
- enablepwm, output, 1: PWM output enable
- run, output, 1: run/brake select

Behaviour:
- Reset: all outputs 0; CTRL=0, target=0, duty=0, fault=0; all dividers and counters 0; FSM in IDLE.
- Dividers: free-running counters. filterce pulses 1 cycle every FILTER_DIV cycles; pwmcntce pulses every PWM_DIV cycles. First pulse of each occurs at cycle DIV-1 after reset release.
- Registers (write):
  - addr0 CTRL: b0 enablepwm, b1 run, b2 invertpwm, b3 invphase, b4 ramp_en, b7 fault_clr (self-clearing, not stored).
  - addr1 TARGET duty.
  - Writes to other addresses are ignored.
- Register outputs: invphase and invertpwm follow CTRL directly. enablepwm = CTRL.b0 & ~fault. run = CTRL.b1 & ~fault.
- Reads:
  - Every rd produces exactly one rdvalid pulse.
  - addr0 CTRL (b7 reads 0); addr1 TARGET; addr2 STATUS {5'b0, freeze, ramp_busy, fault}; addr5 current duty; other addresses read 0.
  - rdvalid is asserted 1 cycle after rd for these addresses.
- Tach read FSM (IDLE, FRZ, HOLD):
  - rd addr3 in IDLE: freeze=1 next cycle (FRZ); following cycle rddata=countl, rdvalid=1, go to HOLD. Latency is 2 cycles.
  - In HOLD, rd addr4: rddata=counth with rdvalid 1 cycle later; freeze drops the cycle after rdvalid; return to IDLE.
  - rd addr4 in IDLE: returns live counth, 1-cycle latency, freeze untouched.
  - rd addr3 in HOLD: re-samples countl, 1-cycle latency, freeze stays high, timeout restarts.
  - HOLD with no addr4 read for FREEZE_TIMEOUT cycles: freeze released, return to IDLE.
  - reset in any state: IDLE with freeze=0.
- Duty ramp:
  - ramp_en=0: a TARGET write sets duty=target and pulses pwmldce the next cycle, with pwmdata=duty.
  - ramp_en=1: every RAMP_DIV cycles, if duty != target, duty moves toward target by 1 and pwmldce pulses for 1 cycle with the new duty.
  - duty saturates; it never wraps past 0 or 255.
  - ramp_busy = ramp_en & (duty != target).
  - A TARGET write mid-ramp retargets with no glitch. The current duty continues from its present value.
- Fault detection:
  - One PWM period = 256 pwmcntce pulses; a period counter tracks boundaries.
  - A period is "limited" if currentlimit was high on any cycle within it.
  - ILIMIT_MAX consecutive limited periods set fault. Any non-limited period resets the consecutive count.
  - On fault: duty=0 and target=0, one pwmldce pulse with pwmdata=0, enablepwm=run=0.
- Fault clear:
  - fault_clr clears fault only when currentlimit=0 that cycle; otherwise fault remains set.
  - Clearing does not restore duty.
  - Simultaneous fault set and clear: set wins.
- Simultaneous events:
  - A fault pwmldce takes priority over a ramp step or TARGET-write load in the same cycle.
  - wr and rd in the same cycle are both serviced, and reads return the pre-write value.

Decomposition:
- Shared package bdc_pkg:
  - address constants ADDR_CTRL..ADDR_DUTY
  - CTRL bit index constants
  - tach FSM state typedef
- One natural sub-module: bdc_ce_divider (parameterised free-running clock-enable generator), instantiated twice for filterce and pwmcntce.

Test Plan:
- Reset, then run 64 cycles with FILTER_DIV=16, PWM_DIV=4 -> filterce pulses at cycles 15,31,47,63; pwmcntce every 4th cycle; all other outputs 0.
- rd addr3 with countl=0x34, then change countl and counth, then rd addr4 with counth=0x12 -> rdvalid with 0x34 at +2; rdvalid with 0x12; freeze high from the cycle after the first rd until the cycle after the second rdvalid.
- rd addr3 with no follow-up read -> freeze drops after exactly FREEZE_TIMEOUT cycles; STATUS b2 reads 0.
- ramp_en=1, RAMP_DIV=4, TARGET=3 from duty 0 -> pwmldce pulses with pwmdata 1,2,3 spaced 4 cycles apart; ramp_busy falls after 3. Then write TARGET=1 -> duty steps 2,1.
- Hold currentlimit high for 8 PWM periods with ILIMIT_MAX=8 -> fault=1, enablepwm=run=0, pwmldce with pwmdata=0. fault_clr while currentlimit=1 -> fault stays 1. fault_clr after currentlimit=0 -> fault 0.
- Assert reset mid-HOLD and mid-ramp -> freeze=0, duty=0, and no pwmldce on the cycle after reset.
